// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer slice.
package tdm_pkg;

    localparam int TDM_DATA_W = 8;
    localparam int TDM_NUM_CH = 4;

    // Framing state: HUNT waits for a start-of-frame, LOCKED routes by slot.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    // Width of a slot index. It is never zero, so a 1-wide field is always legal.
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Sample input bus and per-channel output bus of the TDM demultiplexer.
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int DATA_W = TDM_DATA_W,
    parameter int NUM_CH = TDM_NUM_CH
);
    localparam int SLOT_W = slot_width(NUM_CH);

    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_sof;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [SLOT_W-1:0]        slot;
    logic                     locked;
    logic                     sync_err;

    // Source of the multiplexed stream and consumer of the channels.
    modport master (
        output in_valid, in_data, in_sof,
        input  out_data, out_valid, slot, locked, sync_err
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, in_sof,
        output out_data, out_valid, slot, locked, sync_err
    );

endinterface

// File: rtl/tdm_demux_slot_counter.sv
// Mod-NUM_CH slot counter with synchronous clear, load-to-1 and wrapping increment.
module slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = TDM_NUM_CH,
    parameter int SLOT_W = slot_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_CH - 1);

    // Count register: reset and clear win over load, load wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SLOT_W'(1);
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes each accepted sample to the channel
// holding register selected by the frame slot, with HUNT/LOCKED framing.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int DATA_W = TDM_DATA_W,
    parameter int NUM_CH = TDM_NUM_CH
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);

    localparam int SLOT_W = slot_width(NUM_CH);

    tdm_state_t               state;
    logic [SLOT_W-1:0]        slot_q;
    logic [NUM_CH*DATA_W-1:0] out_data_q;
    logic [NUM_CH-1:0]        out_valid_q;
    logic                     locked_q;
    logic                     sync_err_q;

    logic                     cnt_clr;
    logic                     cnt_load1;
    logic                     cnt_inc;
    logic                     next_locked;
    logic                     err_d;
    logic [NUM_CH-1:0]        we;

    slot_counter #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .cnt   (slot_q)
    );

    // Framing decision and slot-to-channel write-enable decode for this cycle.
    always_comb begin
        cnt_clr     = 1'b0;
        cnt_load1   = 1'b0;
        cnt_inc     = 1'b0;
        err_d       = 1'b0;
        we          = '0;
        next_locked = (state == LOCKED);
        if (bus.in_valid) begin
            if (state == HUNT) begin
                // Non-SOF samples are dropped until a frame start is seen.
                if (bus.in_sof) begin
                    we[0]       = 1'b1;
                    cnt_load1   = 1'b1;
                    next_locked = 1'b1;
                end
            end else if (bus.in_sof) begin
                // An SOF away from slot 0 resynchronises but is flagged.
                we[0]     = 1'b1;
                cnt_load1 = 1'b1;
                err_d     = (slot_q != '0);
            end else if (slot_q != '0) begin
                we[slot_q] = 1'b1;
                cnt_inc    = 1'b1;
            end else begin
                // Slot 0 without SOF: frame lost, drop the sample and re-hunt.
                err_d       = 1'b1;
                cnt_clr     = 1'b1;
                next_locked = 1'b0;
            end
        end
    end

    // Registered FSM state, status pulses and channel holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            state       <= next_locked ? LOCKED : HUNT;
            locked_q    <= next_locked;
            sync_err_q  <= err_d;
            out_valid_q <= we;
            for (int k = 0; k < NUM_CH; k++) begin
                if (we[k]) begin
                    out_data_q[k*DATA_W +: DATA_W] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = locked_q;
    assign bus.sync_err  = sync_err_q;

endmodule
